// File: rtl/avalon_sdram_responder.sv
// avalon_sdram_responder: Avalon-MM slave word memory with programmable
// wait states and a fixed-latency, in-order read response pipeline.
// It is the memory endpoint behind the copy engine's master ports.
module avalon_sdram_responder #(
  parameter int          DEPTH        = 1024,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int          WAIT_STATES  = 1,
  parameter int          READ_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        slave_waitrequest,
  input  logic [31:0] slave_address,
  input  logic        slave_read,
  output logic [31:0] slave_readdata,
  output logic        slave_readdatavalid,
  input  logic        slave_write,
  input  logic [31:0] slave_writedata,
  output logic        err,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [31:0] SPAN     = 32'(4 * DEPTH);
  localparam logic [3:0]  WS       = 4'(WAIT_STATES);
  localparam logic [31:0] OOR_DATA = 32'hDEAD_BEEF;

  // Where the stage-0 response word comes from. SRC_ZERO only exists so
  // that slave_readdata reads 0 out of reset without resetting the RAM
  // output register.
  typedef enum logic [1:0] {
    SRC_ZERO = 2'd0,
    SRC_RAM  = 2'd1,
    SRC_OOR  = 2'd2
  } s0_src_e;

  logic          cmd;
  logic          accept;
  logic          acc_rd;
  logic          acc_wr;
  logic          in_range;
  logic [31:0]   off;
  logic [AW-1:0] idx;

  logic [3:0]    wcnt_q, wcnt_d;
  logic [15:0]   rd_count_q, rd_count_d;
  logic [15:0]   wr_count_q, wr_count_d;
  logic          err_q, err_d;

  logic          s0_valid_q;
  s0_src_e       s0_src_q;
  logic [31:0]   s0_data;
  logic [31:0]   ram_rd_q;

  logic [31:0]   mem [0:DEPTH-1];

  // Per-stage view of the response pipeline; element 0 is the RAM stage.
  logic          stg_v [READ_LATENCY];
  logic [31:0]   stg_d [READ_LATENCY];

  assign cmd               = slave_read | slave_write;
  assign slave_waitrequest = rst | (cmd & (wcnt_q != WS));
  assign accept            = cmd & ~slave_waitrequest;
  // A simultaneous read+write performs the write only; the read is dropped.
  assign acc_wr            = accept & slave_write;
  assign acc_rd            = accept & slave_read & ~slave_write;

  // Offset from the window base; wrap-around below BASE_ADDR lands far
  // above SPAN and therefore decodes as out of range.
  assign off      = slave_address - BASE_ADDR;
  assign in_range = off < SPAN;
  assign idx      = off[AW+1:2];

  // Next-state for the wait counter, transaction counters and error flag.
  always_comb begin
    wcnt_d = wcnt_q;
    if (!cmd || accept) begin
      wcnt_d = 4'd0;
    end else if (wcnt_q < WS) begin
      wcnt_d = wcnt_q + 4'd1;
    end
    rd_count_d = rd_count_q + {15'd0, acc_rd};
    wr_count_d = wr_count_q + {15'd0, acc_wr};
    err_d      = err_q
               | (acc_wr & ~in_range)
               | (acc_rd & ~in_range)
               | (accept & slave_read & slave_write);
  end

  // Control state registers, including the stage-0 valid and data source.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt_q     <= 4'd0;
      rd_count_q <= 16'd0;
      wr_count_q <= 16'd0;
      err_q      <= 1'b0;
      s0_valid_q <= 1'b0;
      s0_src_q   <= SRC_ZERO;
    end else begin
      wcnt_q     <= wcnt_d;
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
      err_q      <= err_d;
      s0_valid_q <= acc_rd;
      if (acc_rd) begin
        s0_src_q <= in_range ? SRC_RAM : SRC_OOR;
      end
    end
  end

  // Single-port RAM with registered read; contents survive reset.
  always_ff @(posedge clk) begin
    if (acc_wr && in_range) begin
      mem[idx] <= slave_writedata;
    end
    if (acc_rd) begin
      ram_rd_q <= mem[idx];
    end
  end

  // Stage-0 response word: held until the next accepted read.
  always_comb begin
    case (s0_src_q)
      SRC_RAM: s0_data = ram_rd_q;
      SRC_OOR: s0_data = OOR_DATA;
      default: s0_data = 32'd0;
    endcase
  end

  assign stg_v[0] = s0_valid_q;
  assign stg_d[0] = s0_data;

  for (genvar gi = 1; gi < READ_LATENCY; gi++) begin : g_stage
    logic        v_q;
    logic [31:0] d_q;

    // Shift every cycle; data only moves with a valid entry, so the last
    // stage keeps presenting the most recent response between pulses.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q <= 1'b0;
        d_q <= 32'd0;
      end else begin
        v_q <= stg_v[gi-1];
        if (stg_v[gi-1]) begin
          d_q <= stg_d[gi-1];
        end
      end
    end

    assign stg_v[gi] = v_q;
    assign stg_d[gi] = d_q;
  end

  assign slave_readdatavalid = stg_v[READ_LATENCY-1];
  assign slave_readdata      = stg_d[READ_LATENCY-1];
  assign err                 = err_q;
  assign rd_count            = rd_count_q;
  assign wr_count            = wr_count_q;

endmodule

// File: tb/tb_avalon_sdram_responder.sv
// Bench for avalon_sdram_responder: two instances (WS=1/RL=2 at base 0 and
// WS=0/RL=3 at a non-zero base) run in lockstep against a transaction-level
// reference model (word array, response queue with due cycles, counters).
module tb_avalon_sdram_responder;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] SPAN  = 32'(4 * DEPTH);
  localparam logic [31:0] BASE0 = 32'h0000_0000;
  localparam logic [31:0] BASE1 = 32'h0001_0000;
  localparam int          WS0 = 1, RL0 = 2;
  localparam int          WS1 = 0, RL1 = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        rd    [2];
  logic        wr    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic        wreq  [2];
  logic        rdv   [2];
  logic        errs  [2];
  logic [31:0] rdata [2];
  logic [15:0] rdc_o [2];
  logic [15:0] wrc_o [2];

  avalon_sdram_responder #(
    .DEPTH(DEPTH), .BASE_ADDR(BASE0), .WAIT_STATES(WS0), .READ_LATENCY(RL0)
  ) u_dut0 (
    .clk(clk), .rst(rst),
    .slave_waitrequest(wreq[0]), .slave_address(addr[0]), .slave_read(rd[0]),
    .slave_readdata(rdata[0]), .slave_readdatavalid(rdv[0]),
    .slave_write(wr[0]), .slave_writedata(wdata[0]),
    .err(errs[0]), .rd_count(rdc_o[0]), .wr_count(wrc_o[0])
  );

  avalon_sdram_responder #(
    .DEPTH(DEPTH), .BASE_ADDR(BASE1), .WAIT_STATES(WS1), .READ_LATENCY(RL1)
  ) u_dut1 (
    .clk(clk), .rst(rst),
    .slave_waitrequest(wreq[1]), .slave_address(addr[1]), .slave_read(rd[1]),
    .slave_readdata(rdata[1]), .slave_readdatavalid(rdv[1]),
    .slave_write(wr[1]), .slave_writedata(wdata[1]),
    .err(errs[1]), .rd_count(rdc_o[1]), .wr_count(wrc_o[1])
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    int          due;
    logic [31:0] d;
  } rsp_t;

  rsp_t        rq     [2][$];
  logic [31:0] mem_m  [2][DEPTH];
  int          held   [2];
  logic [15:0] rdc_m  [2];
  logic [15:0] wrc_m  [2];
  logic        err_m  [2];
  logic [31:0] last_d [2];
  logic [31:0] got_d  [2];
  bit          acc    [2];
  int          cyc;
  int          n_vec;
  int          n_err;

  function automatic logic [31:0] base_of(input int u);
    return (u == 0) ? BASE0 : BASE1;
  endfunction

  function automatic int ws_of(input int u);
    return (u == 0) ? WS0 : WS1;
  endfunction

  function automatic int rl_of(input int u);
    return (u == 0) ? RL0 : RL1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic reset_model(input int u);
    held[u]   = 0;
    rdc_m[u]  = 16'd0;
    wrc_m[u]  = 16'd0;
    err_m[u]  = 1'b0;
    last_d[u] = 32'd0;
    acc[u]    = 1'b0;
    rq[u].delete();
  endtask

  // Compare every observable output of one instance in the current cycle.
  task automatic check_outputs(input int u);
    logic exp_w;
    logic exp_v;
    if (rst) reset_model(u);
    exp_w = rst || ((rd[u] || wr[u]) && held[u] < ws_of(u));
    exp_v = (rq[u].size() > 0) && (rq[u][0].due == cyc);
    if (exp_v) begin
      last_d[u] = rq[u][0].d;
      got_d[u]  = rdata[u];
      void'(rq[u].pop_front());
    end
    chk($sformatf("waitrequest%0d", u), 32'(wreq[u]), 32'(exp_w));
    chk($sformatf("readdatavalid%0d", u), 32'(rdv[u]), 32'(exp_v));
    chk($sformatf("readdata%0d", u), rdata[u], last_d[u]);
    chk($sformatf("err%0d", u), 32'(errs[u]), 32'(err_m[u]));
    chk($sformatf("rd_count%0d", u), 32'(rdc_o[u]), 32'(rdc_m[u]));
    chk($sformatf("wr_count%0d", u), 32'(wrc_o[u]), 32'(wrc_m[u]));
  endtask

  // Apply the effect of the rising edge that ends the current cycle.
  task automatic model_edge(input int u);
    logic [31:0] off;
    logic        inr;
    int          idx;
    acc[u] = 1'b0;
    if (rst) begin
      reset_model(u);
      return;
    end
    if (!(rd[u] || wr[u])) begin
      held[u] = 0;
      return;
    end
    if (held[u] < ws_of(u)) begin
      held[u]++;
      return;
    end
    acc[u]  = 1'b1;
    held[u] = 0;
    off = addr[u] - base_of(u);
    inr = off < SPAN;
    idx = int'(off >> 2);
    if (wr[u]) begin
      if (inr) mem_m[u][idx] = wdata[u];
      else     err_m[u] = 1'b1;
      if (rd[u]) err_m[u] = 1'b1;
      wrc_m[u]++;
    end else begin
      if (!inr) err_m[u] = 1'b1;
      rq[u].push_back('{due: cyc + rl_of(u), d: inr ? mem_m[u][idx] : 32'hDEAD_BEEF});
      rdc_m[u]++;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    for (int u = 0; u < 2; u++) check_outputs(u);
    @(posedge clk);
    for (int u = 0; u < 2; u++) model_edge(u);
    cyc++;
    #1;
  endtask

  // Present one command and hold it until accepted, like the copy engine.
  task automatic issue(input int u, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
    int n;
    n = 0;
    rd[u] = r; wr[u] = w; addr[u] = a; wdata[u] = d;
    do begin
      tick();
      n++;
    end while (!acc[u] && n < 40);
    rd[u] = 1'b0; wr[u] = 1'b0;
    $display("u%0d %s%s addr=%08h data=%08h cycles=%0d", u, r ? "RD" : "", w ? "WR" : "", a, d, n);
  endtask

  task automatic drain();
    for (int n = 0; n < 20 && (rq[0].size() > 0 || rq[1].size() > 0); n++) tick();
    tick();
  endtask

  function automatic logic [31:0] rand_addr(input int u);
    int k;
    k = $urandom_range(0, 9);
    if (k < 8)       return base_of(u) + 32'(4 * $urandom_range(0, 79)) + 32'($urandom_range(0, 3));
    else if (k == 8) return base_of(u) + SPAN + 32'(4 * $urandom_range(0, 255));
    else             return base_of(u) - 32'd4;
  endfunction

  task automatic drive_random(input int u);
    int k;
    if (!(rd[u] || wr[u]) || acc[u]) begin
      k = $urandom_range(0, 99);
      rd[u]    = (k < 40) || (k >= 75 && k < 78);
      wr[u]    = (k >= 40 && k < 78);
      addr[u]  = rand_addr(u);
      wdata[u] = $urandom;
    end else if ($urandom_range(0, 19) == 0) begin
      rd[u] = 1'b0;
      wr[u] = 1'b0;
    end
  endtask

  logic [31:0] cp;

  initial begin
    n_vec = 0; n_err = 0; cyc = 0;
    for (int u = 0; u < 2; u++) begin
      rd[u] = 1'b0; wr[u] = 1'b0; addr[u] = 32'd0; wdata[u] = 32'd0;
      got_d[u] = 32'd0;
      reset_model(u);
    end

    // Reset with a read request asserted.
    rd[0] = 1'b1; rd[1] = 1'b1;
    tick(); tick(); tick();
    rd[0] = 1'b0; rd[1] = 1'b0;
    rst = 1'b0;
    tick();

    // Preload the words used by the rest of the bench.
    for (int u = 0; u < 2; u++)
      for (int i = 0; i < 80; i++)
        issue(u, 1'b0, 1'b1, base_of(u) + 32'(4 * i), $urandom);

    // Write then read back with one wait state, latency 2.
    issue(0, 1'b0, 1'b1, BASE0 + 32'd8, 32'h1234_5678);
    issue(0, 1'b1, 1'b0, BASE0 + 32'd8, 32'd0);
    drain();
    chk("readback", got_d[0], 32'h1234_5678);

    // Back-to-back pipelined reads, no wait states, latency 3.
    for (int i = 0; i < 3; i++) issue(1, 1'b0, 1'b1, BASE1 + 32'(4 * i), 32'(i + 1));
    rd[1] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      addr[1] = BASE1 + 32'(4 * i);
      tick();
    end
    rd[1] = 1'b0;
    drain();
    chk("pipe_last", got_d[1], 32'd3);

    // Out-of-range read and write.
    issue(0, 1'b1, 1'b0, BASE0 + SPAN, 32'd0);
    drain();
    chk("oor_data", got_d[0], 32'hDEAD_BEEF);
    chk("oor_err", 32'(errs[0]), 32'd1);
    issue(0, 1'b0, 1'b1, BASE0 + SPAN, 32'hFFFF_FFFF);
    issue(0, 1'b1, 1'b0, BASE0, 32'd0);
    drain();
    chk("oor_word0", got_d[0], mem_m[0][0]);

    // Read and write presented together.
    issue(1, 1'b1, 1'b1, BASE1 + 32'd4, 32'd7);
    for (int i = 0; i < 4; i++) tick();
    chk("rw_err", 32'(errs[1]), 32'd1);
    issue(1, 1'b1, 1'b0, BASE1 + 32'd4, 32'd0);
    drain();
    chk("rw_data", got_d[1], 32'd7);

    // Reset with two reads in flight.
    rd[1] = 1'b1;
    addr[1] = BASE1; tick();
    addr[1] = BASE1 + 32'd8; tick();
    rd[1] = 1'b0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    issue(1, 1'b1, 1'b0, BASE1, 32'd0);
    drain();
    chk("retained", got_d[1], 32'd1);

    // Copy engine: 4 words from BASE+0x40 to BASE+0x100.
    for (int i = 0; i < 4; i++) begin
      issue(0, 1'b1, 1'b0, BASE0 + 32'h40 + 32'(4 * i), 32'd0);
      drain();
      cp = got_d[0];
      issue(0, 1'b0, 1'b1, BASE0 + 32'h100 + 32'(4 * i), cp);
    end
    for (int i = 0; i < 4; i++) begin
      issue(0, 1'b1, 1'b0, BASE0 + 32'h100 + 32'(4 * i), 32'd0);
      drain();
      chk($sformatf("copy%0d", i), got_d[0], mem_m[0][16 + i]);
    end

    // Randomized traffic on both instances.
    for (int it = 0; it < 2500; it++) begin
      for (int u = 0; u < 2; u++) drive_random(u);
      tick();
    end
    for (int u = 0; u < 2; u++) begin
      rd[u] = 1'b0;
      wr[u] = 1'b0;
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
